btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_debounce_ch.sv | 107 ++++++++++
 rtl/btn_debounce.sv | 38 +++
 tb/tb_btn_debounce.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared timing defaults and active-low level constants for the button debouncer.
package btn_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 270000;    // 10 ms at 27 MHz
  localparam int DEF_REPEAT_DELAY    = 13500000;  // 500 ms at 27 MHz
  localparam int DEF_REPEAT_PERIOD   = 2700000;   // 100 ms at 27 MHz

  localparam logic PRESSED  = 1'b0;
  localparam logic RELEASED = 1'b1;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, edge pulses.
// Optional auto-repeat of the pressed pulse under BTN_AUTOREPEAT_EN.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n_i,
  output logic btn_n_o,
  output logic pressed_o,
  output logic released_o
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
    $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          pr_q, pr_d;
  logic          rl_q, rl_d;
  logic          accept;
  logic          rpt_fire;

  assign sync = sync_q[1];

  // Terminal test uses >= so the counter can never step past its last value.
  always_comb begin
    cnt_d  = cnt_q;
    btn_d  = btn_q;
    accept = 1'b0;
    if (sync == btn_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      accept = 1'b1;
      btn_d  = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    pr_d = (accept && sync == PRESSED) || rpt_fire;
    rl_d = accept && sync == RELEASED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      btn_q  <= RELEASED;
      pr_q   <= 1'b0;
      rl_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_n_i};
      cnt_q  <= cnt_d;
      btn_q  <= btn_d;
      pr_q   <= pr_d;
      rl_q   <= rl_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LOAD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q, rpt_d;

  // Down-counter: loaded at acceptance, fires at zero, reloads with the period.
  // Suppressed on the release-acceptance edge so pressed/released never coincide.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (accept && btn_d == PRESSED) begin
      rpt_d = RD_LOAD;
    end else if (btn_q == PRESSED && !accept) begin
      if (rpt_q == '0) begin
        rpt_fire = 1'b1;
        rpt_d    = RP_LOAD;
      end else begin
        rpt_d = rpt_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign btn_n_o    = btn_q;
  assign pressed_o  = pr_q;
  assign released_o = rl_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer with press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pressed pulses while held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw_n,
  output logic [NUM_BTNS-1:0] btn_n,
  output logic [NUM_BTNS-1:0] pressed,
  output logic [NUM_BTNS-1:0] released
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw_n_i    (btn_raw_n[i]),
      .btn_n_o    (btn_n[i]),
      .pressed_o  (pressed[i]),
      .released_o (released[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_btn_debounce;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw_n = '1;
  logic [N-1:0] btn_n, pressed, released;

  int nvec = 0;
  int nerr = 0;

  btn_debounce #(
    .NUM_BTNS        (N),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw_n (btn_raw_n),
    .btn_n     (btn_n),
    .pressed   (pressed),
    .released  (released)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check all three outputs at once against expected values.
  task automatic chk3(input string tag, input logic [N-1:0] eb, input logic [N-1:0] ep,
                      input logic [N-1:0] er);
    chk({tag, ".btn_n"},    8'(btn_n),    8'(eb));
    chk({tag, ".pressed"},  8'(pressed),  8'(ep));
    chk({tag, ".released"}, 8'(released), 8'(er));
  endtask

  logic [N-1:0] ep;

  initial begin
    // Reset with buttons held low: no pulses, idle levels.
    btn_raw_n = 2'b00;
    rst = 1'b1;
    repeat (3) step();
    chk3("reset", 2'b11, 2'b00, 2'b00);
    btn_raw_n = 2'b11;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk3("post_reset", 2'b11, 2'b00, 2'b00);

    // Clean press on channel 0: accepted exactly 6 edges after first sampling edge.
    btn_raw_n = 2'b10;
    repeat (5) step();
    chk3("press_e5", 2'b11, 2'b00, 2'b00);
    step();
    chk3("press_e6", 2'b10, 2'b01, 2'b00);
    step();
    chk3("press_e7", 2'b10, 2'b00, 2'b00);

    // Release on channel 0.
    btn_raw_n = 2'b11;
    repeat (5) step();
    chk3("rel_e5", 2'b10, 2'b00, 2'b00);
    step();
    chk3("rel_e6", 2'b11, 2'b00, 2'b01);
    step();
    chk3("rel_e7", 2'b11, 2'b00, 2'b00);

    // Bounce: 2 cycles low / 2 cycles high never reaches 4 stable cycles.
    for (int k = 0; k < 20; k++) begin
      btn_raw_n = (k % 4 < 2) ? 2'b10 : 2'b11;
      step();
      chk3("bounce", 2'b11, 2'b00, 2'b00);
    end
    btn_raw_n = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      chk3("bounce_hold", 2'b11, 2'b00, 2'b00);
    end

    // Both channels at once.
    btn_raw_n = 2'b00;
    repeat (5) step();
    chk3("sim_press_e5", 2'b11, 2'b00, 2'b00);
    step();
    chk3("sim_press_e6", 2'b00, 2'b11, 2'b00);
    step();
    chk3("sim_press_e7", 2'b00, 2'b00, 2'b00);
    btn_raw_n = 2'b11;
    repeat (5) step();
    chk3("sim_rel_e5", 2'b00, 2'b00, 2'b00);
    step();
    chk3("sim_rel_e6", 2'b11, 2'b00, 2'b11);
    step();
    chk3("sim_rel_e7", 2'b11, 2'b00, 2'b00);

    // Reset while the channel-0 counter sits at 3 (after edge 5).
    btn_raw_n = 2'b10;
    repeat (5) step();
    chk3("midrst_pre", 2'b11, 2'b00, 2'b00);
    rst = 1'b1;
    step();
    chk3("midrst_in", 2'b11, 2'b00, 2'b00);
    rst = 1'b0;
    repeat (5) step();
    chk3("midrst_e5", 2'b11, 2'b00, 2'b00);
    step();
    chk3("midrst_e6", 2'b10, 2'b01, 2'b00);

    // Hold 30 cycles after acceptance: repeat pulses only when enabled.
    for (int j = 1; j <= 30; j++) begin
      step();
`ifdef BTN_AUTOREPEAT_EN
      ep = (j == 10 || j == 15 || j == 20 || j == 25 || j == 30) ? 2'b01 : 2'b00;
`else
      ep = 2'b00;
`endif
      chk3($sformatf("hold_%0d", j), 2'b10, ep, 2'b00);
    end

    // Release after the hold; repeats may continue during debounce, so check levels/release only.
    btn_raw_n = 2'b11;
    repeat (5) step();
    chk("hold_rel_e5.released", 8'(released), 8'(2'b00));
    chk("hold_rel_e5.btn_n",    8'(btn_n),    8'(2'b10));
    step();
    chk3("hold_rel_e6", 2'b11, 2'b00, 2'b01);
    repeat (12) step();
    chk3("idle_end", 2'b11, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
